// File: rtl/sobel_window_gen.sv
// 3x3 window generator feeding the Sobel gradient stage from a raster pixel stream.
// Latency: one cycle from an accepted interior beat to start with its window on px11..px33.
// No backpressure: every valid beat is taken; idle cycles hold all state and drop start.
module sobel_window_gen #(
  parameter int PIX_W      = 16,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sof,
  input  logic [PIX_W-1:0] pixel_in,
  input  logic             pixel_valid,
  output logic [PIX_W-1:0] px11,
  output logic [PIX_W-1:0] px12,
  output logic [PIX_W-1:0] px13,
  output logic [PIX_W-1:0] px21,
  output logic [PIX_W-1:0] px22,
  output logic [PIX_W-1:0] px23,
  output logic [PIX_W-1:0] px31,
  output logic [PIX_W-1:0] px32,
  output logic [PIX_W-1:0] px33,
  output logic             start,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic            r_start;
  logic            r_done;
  logic            w_start_nxt;
  logic            w_done_nxt;

  // Line buffers: r_lb0 holds the previous line, r_lb1 the one before it.
  logic [PIX_W-1:0] r_lb0 [IMG_WIDTH];
  logic [PIX_W-1:0] r_lb1 [IMG_WIDTH];

  // Window registers, [row][col] with index 0 the oldest.
  logic [PIX_W-1:0] r_win [3][3];

  logic             w_accept;
  logic [CW-1:0]    w_col;
  logic [RW-1:0]    w_row;
  logic             w_last_col;
  logic             w_last_row;
  logic [PIX_W-1:0] w_top;
  logic [PIX_W-1:0] w_mid;

  // A sof beat is always pixel (0,0), whatever the counters currently say.
  assign w_accept   = pixel_valid && (sof || (r_state != IDLE));
  assign w_col      = sof ? '0 : r_col;
  assign w_row      = sof ? '0 : r_row;
  assign w_last_col = (w_col == CW'(IMG_WIDTH - 1));
  assign w_last_row = (w_row == RW'(IMG_HEIGHT - 1));
  assign w_top      = r_lb1[w_col];
  assign w_mid      = r_lb0[w_col];

  // Next state plus the registered start/frame_done pulses.
  always_comb begin
    w_state_nxt = r_state;
    w_start_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    if (w_accept) begin
      // Column gate also suppresses windows straddling a row wrap.
      w_start_nxt = (w_row >= RW'(2)) && (w_col >= CW'(2));
      if (sof) begin
        // Restart wins over any frame_done of the beat it lands on.
        w_state_nxt = FILL;
      end else begin
        case (r_state)
          FILL: if (w_last_col && (w_row == RW'(1))) w_state_nxt = RUN;
          RUN: begin
            if (w_last_col && w_last_row) begin
              w_state_nxt = IDLE;
              w_done_nxt  = 1'b1;
            end
          end
          default: w_state_nxt = r_state;
        endcase
      end
    end
  end

  // FSM, raster counters and output pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_start <= w_start_nxt;
      r_done  <= w_done_nxt;
      if (w_accept) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : w_row + RW'(1);
        end else begin
          r_col <= w_col + CW'(1);
          r_row <= w_row;
        end
      end
    end
  end

  // Line-buffer update; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb1[w_col] <= w_mid;
      r_lb0[w_col] <= pixel_in;
    end
  end

  // Shift the window left and load the new column on the right.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          r_win[i][j] <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < 3; i++) begin
        r_win[i][0] <= r_win[i][1];
        r_win[i][1] <= r_win[i][2];
      end
      r_win[0][2] <= w_top;
      r_win[1][2] <= w_mid;
      r_win[2][2] <= pixel_in;
    end
  end

  assign px11       = r_win[0][0];
  assign px12       = r_win[0][1];
  assign px13       = r_win[0][2];
  assign px21       = r_win[1][0];
  assign px22       = r_win[1][1];
  assign px23       = r_win[1][2];
  assign px31       = r_win[2][0];
  assign px32       = r_win[2][1];
  assign px33       = r_win[2][2];
  assign start      = r_start;
  assign frame_done = r_done;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 4x4 image.
// Each beat is driven at the falling edge and outputs are sampled 1 ns after the rising edge.
// Window contents come from a hand-written table of the four interior windows of a 1..16 frame.
module tb_sobel_window_gen;
  localparam int PW = 16;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sof = 1'b0;
  logic          pixel_valid = 1'b0;
  logic [PW-1:0] pixel_in = '0;
  logic [PW-1:0] px11, px12, px13, px21, px22, px23, px31, px32, px33;
  logic          start, frame_done, busy;

  int n_chk   = 0;
  int n_fail  = 0;
  int n_start = 0;

  // Interior windows of a frame holding 1..16, order px11..px33, hand-computed.
  int win_tbl [4][9] = '{
    '{1, 2, 3, 5, 6, 7,  9, 10, 11},
    '{2, 3, 4, 6, 7, 8, 10, 11, 12},
    '{5, 6, 7, 9, 10, 11, 13, 14, 15},
    '{6, 7, 8, 10, 11, 12, 14, 15, 16}
  };

  always #5 clk = ~clk;

  sobel_window_gen #(.PIX_W(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .sof(sof), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .px11(px11), .px12(px12), .px13(px13), .px21(px21), .px22(px22), .px23(px23),
    .px31(px31), .px32(px32), .px33(px33),
    .start(start), .frame_done(frame_done), .busy(busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic s, input logic v, input logic [PW-1:0] p);
    @(negedge clk);
    sof = s;
    pixel_valid = v;
    pixel_in = p;
    @(posedge clk);
    #1;
    if (start === 1'b1) n_start++;
  endtask

  task automatic check_win(input string tag, input int base, input int idx);
    logic [PW-1:0] obs [9];
    obs = '{px11, px12, px13, px21, px22, px23, px31, px32, px33};
    for (int j = 0; j < 9; j++)
      check_val($sformatf("%s_px%0d%0d", tag, j / 3 + 1, j % 3 + 1), 32'(obs[j]),
                32'(base + win_tbl[idx][j]));
  endtask

  // Sends pixels base+1..base+npix with sof on the first; optional idle cycle between beats.
  task automatic send_frame(input int base, input int npix, input bit gaps);
    for (int k = 0; k < npix; k++) begin
      int  r, c;
      bit  exp_s;
      string tag;
      r = k / W;
      c = k % W;
      tag = $sformatf("b%0d_p%0d", base, k + 1);
      if (gaps && k > 0) begin
        cycle(1'b0, 1'b0, '0);
        check_val({tag, "_gap_start"}, 32'(start), 32'd0);
        check_val({tag, "_gap_done"}, 32'(frame_done), 32'd0);
      end
      cycle(k == 0, 1'b1, PW'(base + k + 1));
      exp_s = (r >= 2) && (c >= 2);
      check_val({tag, "_start"}, 32'(start), 32'(exp_s));
      if (exp_s) check_win(tag, base, (r - 2) * (W - 2) + (c - 2));
      check_val({tag, "_done"}, 32'(frame_done), 32'(k == W * H - 1));
      check_val({tag, "_busy"}, 32'(busy), 32'(k != W * H - 1));
    end
  endtask

  initial begin
    int s0;
    #2;
    check_val("rst_start", 32'(start), 32'd0);
    check_val("rst_done", 32'(frame_done), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_px22", 32'(px22), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Tests 1/2: back-to-back frame.
    s0 = n_start;
    send_frame(0, 16, 1'b0);
    check_val("t1_starts", 32'(n_start - s0), 32'd4);
    cycle(1'b0, 1'b0, '0);
    check_val("t2_done_one_cycle", 32'(frame_done), 32'd0);

    // Test 3: idle cycle between every beat.
    s0 = n_start;
    send_frame(0, 16, 1'b1);
    check_val("t3_starts", 32'(n_start - s0), 32'd4);

    // Test 4: abort after 6 pixels, restart with sof.
    s0 = n_start;
    send_frame(0, 6, 1'b0);
    send_frame(100, 16, 1'b0);
    check_val("t4_starts", 32'(n_start - s0), 32'd4);

    // Test 5: async reset after pixel 10.
    send_frame(200, 10, 1'b0);
    check_val("t5_busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check_val("t5_px11", 32'(px11), 32'd0);
    check_val("t5_px23", 32'(px23), 32'd0);
    check_val("t5_px33", 32'(px33), 32'd0);
    check_val("t5_start", 32'(start), 32'd0);
    check_val("t5_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, PW'(77));
      check_val($sformatf("t5_ign%0d_busy", i), 32'(busy), 32'd0);
      check_val($sformatf("t5_ign%0d_start", i), 32'(start), 32'd0);
      check_val($sformatf("t5_ign%0d_px33", i), 32'(px33), 32'd0);
    end
    send_frame(300, 16, 1'b0);

    // Test 6: two frames back-to-back, sof right after the last pixel.
    s0 = n_start;
    send_frame(400, 16, 1'b0);
    send_frame(500, 16, 1'b0);
    check_val("t6_starts", 32'(n_start - s0), 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
